prbs_checker: RTL and testbench

//  Receive-side consumer of the PRBS byte stream. Verifies the training preamble:
//  N repetitions of a 32-bit pattern, sent LSB byte first.

---
 rtl/prbs_pkg.sv | 17 +
 rtl/prbs_checker_if.sv | 22 ++
 rtl/prbs_lfsr16.sv | 29 ++
 rtl/prbs_checker.sv | 133 +++++++++++++
 tb/tb_prbs_checker.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared types and LFSR step function for the PRBS generator/checker pair.
package prbs_pkg;

  localparam int LFSR_W = 16;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PREAMBLE = 2'd1,
    PRBS     = 2'd2
  } chk_state_e;

  // Shift left, feedback from taps 15 and 14 into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[15] ^ s[14]};
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Byte link plus configuration and status of the PRBS checker.
interface prbs_checker_if #(parameter int ERR_W = 16);
  logic             valid_i;
  logic [7:0]       data_i;
  logic [31:0]      pattern_i;
  logic [7:0]       n_i;
  logic             clr_i;
  logic             pattern_ok_o;
  logic             prbs_lock_o;
  logic             prbs_err_o;
  logic [ERR_W-1:0] err_count_o;

  modport master (
    output valid_i, data_i, pattern_i, n_i, clr_i,
    input  pattern_ok_o, prbs_lock_o, prbs_err_o, err_count_o
  );

  modport slave (
    input  valid_i, data_i, pattern_i, n_i, clr_i,
    output pattern_ok_o, prbs_lock_o, prbs_err_o, err_count_o
  );
endinterface

// File: rtl/prbs_lfsr16.sv
// Local reference LFSR: async reset and sync load take the seed, enable steps it.
module prbs_lfsr16
  import prbs_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              load_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)    lfsr_d = seed_i;
    else if (en_i) lfsr_d = lfsr16_next(lfsr_q);
  end

  // Seed is static while out of reset, so the async load value is stable.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lfsr_q <= seed_i;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: verifies the repeated 32-bit preamble, then
// checks every following byte against a self-seeded local LFSR.
//
// state    | meaning
// HUNT     | waiting for pattern byte 0
// PREAMBLE | matching pattern bytes; byte_idx/rep_cnt track position
// PRBS     | checking bytes against the local LFSR; terminal until reset
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int ERR_W       = 16,
  parameter int LOCK_THRESH = 8
) (
  input logic            CLK,
  input logic            RSTn,
  prbs_checker_if.slave  bus
);

  chk_state_e        state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        rep_cnt_q, rep_cnt_d;
  logic [7:0]        good_run_q, good_run_d;
  logic              ok_q, ok_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        exp_byte;
  logic [7:0]        last_rep;

  assign exp_byte = bus.pattern_i[{byte_idx_q, 3'b000} +: 8];
  // n=0 wraps to 255, giving 256 repetitions.
  assign last_rep = bus.n_i - 8'd1;

  prbs_lfsr16 u_lfsr (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .seed_i  (bus.pattern_i[LFSR_W-1:0]),
    .load_i  (state_q != PRBS),
    .en_i    (bus.valid_i && (state_q == PRBS)),
    .state_o (lfsr)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    rep_cnt_d  = rep_cnt_q;
    good_run_d = good_run_q;
    ok_d       = ok_q;
    lock_d     = lock_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (bus.valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (bus.data_i == bus.pattern_i[7:0]) begin
            state_d    = PREAMBLE;
            byte_idx_d = 2'd1;
            rep_cnt_d  = 8'd0;
          end
        end
        PREAMBLE: begin
          if (bus.data_i == exp_byte) begin
            if (byte_idx_q != 2'd3) begin
              byte_idx_d = byte_idx_q + 2'd1;
            end else if (rep_cnt_q == last_rep) begin
              ok_d       = 1'b1;
              state_d    = PRBS;
              byte_idx_d = 2'd0;
            end else begin
              rep_cnt_d  = rep_cnt_q + 8'd1;
              byte_idx_d = 2'd0;
            end
          end else begin
            rep_cnt_d = 8'd0;
            if (bus.data_i == bus.pattern_i[7:0]) begin
              byte_idx_d = 2'd1;
            end else begin
              state_d    = HUNT;
              byte_idx_d = 2'd0;
            end
          end
        end
        PRBS: begin
          if (bus.data_i != lfsr[7:0]) begin
            err_d      = 1'b1;
            good_run_d = 8'd0;
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
          end else begin
            if (good_run_q != 8'hFF) good_run_d = good_run_q + 8'd1;
            if (good_run_d >= 8'(LOCK_THRESH)) lock_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (bus.clr_i) begin
      err_d      = 1'b0;
      err_cnt_d  = '0;
      good_run_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= HUNT;
      byte_idx_q <= 2'd0;
      rep_cnt_q  <= 8'd0;
      good_run_q <= 8'd0;
      ok_q       <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      rep_cnt_q  <= rep_cnt_d;
      good_run_q <= good_run_d;
      ok_q       <= ok_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.pattern_ok_o = ok_q;
  assign bus.prbs_lock_o  = lock_q;
  assign bus.prbs_err_o   = err_q;
  assign bus.err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a per-cycle reference model.
module tb_prbs_checker;
  localparam int ERR_W       = 8;
  localparam int LOCK_THRESH = 8;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  prbs_checker_if #(.ERR_W(ERR_W)) bus ();

  prbs_checker #(.ERR_W(ERR_W), .LOCK_THRESH(LOCK_THRESH)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int gap_pct = 0;
  logic [15:0] g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: position counted through the whole preamble.
  int          m_phase;   // 0 hunt, 1 preamble, 2 prbs
  int          m_pos;
  int          m_good;
  int          m_cnt;
  bit          m_ok, m_lock, m_err;
  logic [15:0] m_lfsr;

  task automatic model_reset();
    m_phase = 0; m_pos = 0; m_good = 0; m_cnt = 0;
    m_ok = 0; m_lock = 0; m_err = 0;
    m_lfsr = bus.pattern_i[15:0];
  endtask

  task automatic model_step();
    int   nreps;
    logic [7:0] d, e;
    d = bus.data_i;
    nreps = (bus.n_i == 8'd0) ? 256 : int'(bus.n_i);
    m_err = 0;
    if (bus.valid_i) begin
      if (m_phase == 0) begin
        if (d == bus.pattern_i[7:0]) begin m_phase = 1; m_pos = 1; end
      end else if (m_phase == 1) begin
        e = bus.pattern_i[8*(m_pos%4) +: 8];
        if (d == e) begin
          m_pos++;
          if (m_pos == 4*nreps) begin m_ok = 1; m_phase = 2; end
        end else if (d == bus.pattern_i[7:0]) m_pos = 1;
        else begin m_phase = 0; m_pos = 0; end
      end else begin
        e = m_lfsr[7:0];
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14]};
        if (d != e) begin
          m_err = 1; m_good = 0;
          if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
        end else begin
          if (m_good < 255) m_good++;
          if (m_good >= LOCK_THRESH) m_lock = 1;
        end
      end
    end
    if (bus.clr_i) begin m_err = 0; m_cnt = 0; m_good = 0; end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RSTn) model_reset();
      else       model_step();
      chk("pattern_ok", 32'(bus.pattern_ok_o), 32'(m_ok));
      chk("prbs_lock",  32'(bus.prbs_lock_o),  32'(m_lock));
      chk("prbs_err",   32'(bus.prbs_err_o),   32'(m_err));
      chk("err_count",  32'(bus.err_count_o),  32'(m_cnt));
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    @(negedge CLK);
    bus.valid_i = v; bus.data_i = d; bus.clr_i = c;
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic c = 1'b0);
    while (int'($urandom_range(99)) < gap_pct) drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, b, c);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_pre(input int nbytes);
    for (int i = 0; i < nbytes; i++) send(bus.pattern_i[8*(i%4) +: 8]);
  endtask

  task automatic send_prbs(input int k, input logic [7:0] flip = 8'h00, input logic c = 1'b0);
    for (int i = 0; i < k; i++) begin
      send(g[7:0] ^ flip, c);
      g = {g[14:0], g[15] ^ g[14]};
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    bus.valid_i = 1'b0; bus.clr_i = 1'b0;
    RSTn = 1'b0;
    #1;
    chk("rst_ok",   32'(bus.pattern_ok_o), 32'd0);
    chk("rst_lock", 32'(bus.prbs_lock_o),  32'd0);
    chk("rst_cnt",  32'(bus.err_count_o),  32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    g = bus.pattern_i[15:0];
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.data_i = 8'h00; bus.clr_i = 1'b0;
    bus.pattern_i = 32'hA5C30F96; bus.n_i = 8'd3;
    repeat (3) @(negedge CLK);
    do_reset();

    // Clean preamble, then PRBS to lock.
    idle(2);
    send_pre(11);
    chk("t1_ok_early", 32'(bus.pattern_ok_o), 32'd0);
    send_pre(12);  // only byte 11 of this is new position? no: restart index
    chk("t1_ok", 32'(bus.pattern_ok_o), 32'd1);
    send_prbs(1);
    chk("t1_first_prbs_err", 32'(bus.prbs_err_o), 32'd0);
    chk("t1_gen_byte2", 32'(g[7:0]), 32'h2C);
    chk("t1_model_byte2", 32'(m_lfsr[7:0]), 32'h2C);
    send_prbs(6);
    chk("t1_lock_at7", 32'(bus.prbs_lock_o), 32'd0);
    send_prbs(1);
    chk("t1_lock_at8", 32'(bus.prbs_lock_o), 32'd1);

    // Single corrupted byte.
    send_prbs(1, 8'h01);
    chk("t2_err_pulse", 32'(bus.prbs_err_o), 32'd1);
    chk("t2_cnt", 32'(bus.err_count_o), 32'd1);
    chk("t2_lock_kept", 32'(bus.prbs_lock_o), 32'd1);
    send_prbs(1);
    chk("t2_err_clear", 32'(bus.prbs_err_o), 32'd0);

    // clr coinciding with a mismatch wins.
    send_prbs(1, 8'h10, 1'b1);
    chk("clr_err", 32'(bus.prbs_err_o), 32'd0);
    chk("clr_cnt", 32'(bus.err_count_o), 32'd0);

    // Saturation, clr, reset mid-PRBS.
    send_prbs((1 << ERR_W) + 3, 8'hFF);
    chk("sat_cnt", 32'(bus.err_count_o), 32'((1 << ERR_W) - 1));
    drive(1'b0, 8'h00, 1'b1);
    chk("sat_clr", 32'(bus.err_count_o), 32'd0);
    send_prbs(3, 8'h01);
    do_reset();

    // Broken preamble returns to HUNT, then a clean one.
    send(8'h96); send(8'h0F); send(8'h00);
    send_pre(11);
    chk("t3_ok_early", 32'(bus.pattern_ok_o), 32'd0);
    send(8'hA5);
    chk("t3_ok", 32'(bus.pattern_ok_o), 32'd1);
    send_prbs(4);

    // n=0 means 256 repetitions.
    bus.n_i = 8'd0;
    do_reset();
    send_pre(1020);
    chk("t4_ok_rep255", 32'(bus.pattern_ok_o), 32'd0);
    send_pre(4);
    chk("t4_ok_rep256", 32'(bus.pattern_ok_o), 32'd1);
    send_prbs(2);

    // Random valid gaps everywhere.
    bus.n_i = 8'd3;
    do_reset();
    gap_pct = 30;
    send_pre(12);
    send_prbs(10);
    send_prbs(1, 8'h40);
    send_prbs(5);
    gap_pct = 0;
    idle(2);
    chk("t5_ok", 32'(bus.pattern_ok_o), 32'd1);
    chk("t5_lock", 32'(bus.prbs_lock_o), 32'd1);
    chk("t5_cnt", 32'(bus.err_count_o), 32'd1);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
